// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// buffers the returned word for decode and squashes wrong-path fetches on redirect.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic        r_req_valid;
    logic        r_if_valid;
    logic        w_if_valid_nxt;
    logic [31:0] r_if_pc;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] r_if_instr;
    logic [31:0] w_if_instr_nxt;
    logic        r_misalign;
    logic        w_req_fire;
    logic [31:0] w_redirect_pc_al;

    assign w_req_fire       = r_req_valid & imem_req_ready;
    assign w_redirect_pc_al = {redirect_pc[31:2], 2'b00};

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_kill_nxt     = r_kill;
        w_if_valid_nxt = r_if_valid;
        w_if_pc_nxt    = r_if_pc;
        w_if_instr_nxt = r_if_instr;
        case (r_state)
            S_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                    // A redirect racing the handshake leaves a stale request in flight.
                    w_kill_nxt  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_kill || redirect_valid) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_if_instr_nxt = imem_rsp_data;
                        w_if_pc_nxt    = r_pc;
                        w_if_valid_nxt = 1'b1;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_kill_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || if_ready) begin
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = S_REQ;
                    if (if_ready) begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
        // Redirect overrides every other PC update, including a completed decode handshake.
        if (redirect_valid) begin
            w_pc_nxt = w_redirect_pc_al;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_req_valid <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_pc     <= RESET_PC;
            r_if_instr  <= 32'd0;
            r_misalign  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_kill      <= w_kill_nxt;
            r_req_valid <= (w_state_nxt == S_REQ);
            r_if_valid  <= w_if_valid_nxt;
            r_if_pc     <= w_if_pc_nxt;
            r_if_instr  <= w_if_instr_nxt;
            r_misalign  <= redirect_valid & (|redirect_pc[1:0]);
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_if_pc;
    assign if_pc_plus4    = r_if_pc + 32'd4;
    assign if_instr       = r_if_instr;
    assign misalign_err   = r_misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC-level reference model checked every cycle, plus
// directed scenarios with literal expectations (two instances, two reset PCs).
module tb_fetch_ctrl;

    localparam logic [31:0] RP1 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: RESET_PC = 0
    logic        rst, redir_v, req_v, req_rdy, rsp_v, ifv, ifr, mis;
    logic [31:0] redir_pc, req_addr, rsp_data, ifpc, ifp4, ifins;
    // instance 1: RESET_PC = FFFF_FFFC
    logic        rst1, redir_v1, req_v1, req_rdy1, rsp_v1, ifv1, ifr1, mis1;
    logic [31:0] redir_pc1, req_addr1, rsp_data1, ifpc1, ifp41, ifins1;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redir_v), .redirect_pc(redir_pc),
        .imem_req_valid(req_v), .imem_req_ready(req_rdy), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_v), .imem_rsp_data(rsp_data),
        .if_valid(ifv), .if_ready(ifr), .if_pc(ifpc), .if_pc_plus4(ifp4),
        .if_instr(ifins), .misalign_err(mis)
    );

    fetch_ctrl #(.RESET_PC(RP1)) dut1 (
        .clk(clk), .rst(rst1), .redirect_valid(redir_v1), .redirect_pc(redir_pc1),
        .imem_req_valid(req_v1), .imem_req_ready(req_rdy1), .imem_req_addr(req_addr1),
        .imem_rsp_valid(rsp_v1), .imem_rsp_data(rsp_data1),
        .if_valid(ifv1), .if_ready(ifr1), .if_pc(ifpc1), .if_pc_plus4(ifp41),
        .if_instr(ifins1), .misalign_err(mis1)
    );

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- memory models ----------------
    bit          ready_cfg = 1'b1;
    int          lat = 1;

    initial begin : mem0
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 0; cnt = 0; paddr = '0;
        rsp_v = 0; rsp_data = '0; req_rdy = 0;
        forever begin
            @(negedge clk); #1;
            rsp_v = 0;
            if (rst) pend = 0;
            else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    rsp_v = 1; rsp_data = instr_of(paddr); pend = 0;
                end
            end
            req_rdy = ready_cfg;
            if (!rst && req_v && req_rdy) begin
                pend = 1; paddr = req_addr; cnt = lat;
            end
        end
    end

    initial begin : mem1
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 0; cnt = 0; paddr = '0;
        rsp_v1 = 0; rsp_data1 = '0; req_rdy1 = 1;
        forever begin
            @(negedge clk); #1;
            rsp_v1 = 0;
            if (rst1) pend = 0;
            else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    rsp_v1 = 1; rsp_data1 = instr_of(paddr); pend = 0;
                end
            end
            if (!rst1 && req_v1 && req_rdy1) begin
                pend = 1; paddr = req_addr1; cnt = 3;
            end
        end
    end

    // ---------------- reference model + per-cycle compare (instance 0) ----------------
    int          cyc = 0;
    bit          model_on = 0, prev_rst = 0, prev_hold = 0;
    logic [31:0] exp_pc = '0;
    bit          exp_mis = 0;
    int          outst = 0;
    int          t_rel = -1, t_fire = -1, t_ifv = -1;
    int          fcyc[$];
    logic [31:0] reqs[$];
    logic [31:0] dlv[$];

    initial begin : model0
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (model_on) begin
                if (prev_rst) begin
                    chk("rst_req_valid", 32'(req_v), 32'd0);
                    chk("rst_req_addr", req_addr, 32'h0);
                    chk("rst_if_valid", 32'(ifv), 32'd0);
                    chk("rst_misalign", 32'(mis), 32'd0);
                end else begin
                    if (req_v) begin
                        chk("req_addr", req_addr, exp_pc);
                        chk("one_outstanding", 32'(outst), 32'd0);
                        chk("no_req_in_hold", 32'(ifv), 32'd0);
                    end
                    if (ifv) begin
                        chk("if_pc", ifpc, exp_pc);
                        chk("if_pc_plus4", ifp4, exp_pc + 32'd4);
                        chk("if_instr", ifins, instr_of(exp_pc));
                        if (t_ifv < 0) t_ifv = cyc;
                    end
                    chk("misalign", 32'(mis), 32'(exp_mis));
                    if (prev_hold) chk("hold_valid", 32'(ifv), 32'd1);
                end
            end
            if (rst) begin
                model_on = 1; prev_rst = 1; prev_hold = 0;
                exp_pc = 32'h0; exp_mis = 0; outst = 0;
                t_rel = -1; t_fire = -1; t_ifv = -1;
                fcyc.delete();
            end else if (model_on) begin
                if (prev_rst) t_rel = cyc;
                prev_rst = 0;
                if (rsp_v && outst > 0) outst--;
                if (req_v && req_rdy) begin
                    outst++;
                    reqs.push_back(req_addr);
                    fcyc.push_back(cyc);
                    if (t_fire < 0) t_fire = cyc;
                end
                if (ifv && ifr) dlv.push_back(ifpc);
                prev_hold = ifv && !ifr && !redir_v;
                exp_mis = redir_v && (redir_pc[1:0] != 2'b00);
                if (redir_v) exp_pc = {redir_pc[31:2], 2'b00};
                else if (ifv && ifr) exp_pc = exp_pc + 32'd4;
            end
        end
    end

    // ---------------- observer (instance 1) ----------------
    logic [31:0] reqs1[$];
    bit          seen1 = 0;
    logic [31:0] pc1_s = '0, p41_s = '0, ins1_s = '0;

    initial begin : obs1
        forever begin
            @(negedge clk); #2;
            if (!rst1 && req_v1 && req_rdy1) reqs1.push_back(req_addr1);
            if (!rst1 && ifv1 && !seen1) begin
                seen1 = 1; pc1_s = ifpc1; p41_s = ifp41; ins1_s = ifins1;
            end
        end
    end

    // which: 0 dlv size, 1 reqs size, 2 if_valid, 3 reqs1 size, 4 seen1
    task automatic wait_for(input int which, input int n, input string nm);
        int k;
        bit ok;
        k = 0; ok = 0;
        while (!ok && k < 200) begin
            @(negedge clk); #3;
            k++;
            case (which)
                0:       ok = (dlv.size() >= n);
                1:       ok = (reqs.size() >= n);
                2:       ok = (ifv === 1'b1);
                3:       ok = (reqs1.size() >= n);
                default: ok = seen1;
            endcase
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : main
        int n;
        rst = 1; redir_v = 0; redir_pc = '0; ifr = 1;
        rst1 = 1; redir_v1 = 0; redir_pc1 = '0; ifr1 = 1;

        // reset state, then in-order stream with ready memory
        @(negedge clk); #3;
        chk("t1_rst_req_valid", 32'(req_v), 32'd0);
        chk("t1_rst_req_addr", req_addr, 32'h0);
        chk("t1_rst_if_valid", 32'(ifv), 32'd0);
        chk("t1_rst_if_pc", ifpc, 32'h0);
        chk("t1_rst_if_pc_plus4", ifp4, 32'h4);
        chk("t1_rst_if_instr", ifins, 32'h0);
        chk("t1_rst_misalign", 32'(mis), 32'd0);
        @(negedge clk); rst = 0; reqs.delete(); dlv.delete();
        wait_for(0, 4, "t1_deliver_timeout");
        for (int i = 0; i < 4; i++) begin
            chk("t1_req_addr", reqs[i], 32'(4 * i));
            chk("t1_dlv_pc", dlv[i], 32'(4 * i));
        end
        chk("t1_req_after_rst", 32'(t_fire - t_rel), 32'd1);
        chk("t1_latency", 32'(t_ifv - t_fire), 32'd2);
        chk("t1_throughput", 32'(fcyc[1] - fcyc[0]), 32'd3);

        // decode stall for several cycles
        @(negedge clk); ifr = 0;
        wait_for(2, 0, "t2_valid_timeout");
        n = reqs.size();
        repeat (5) @(negedge clk);
        #3;
        chk("t2_hold_valid", 32'(ifv), 32'd1);
        chk("t2_hold_pc", ifpc, 32'h10);
        chk("t2_hold_instr", ifins, instr_of(32'h10));
        chk("t2_no_new_req", 32'(reqs.size()), 32'(n));
        @(negedge clk); ifr = 1;

        // redirect while waiting on a slow response
        @(negedge clk); rst = 1; lat = 3;
        @(negedge clk); rst = 0; reqs.delete(); dlv.delete();
        wait_for(1, 3, "t3_req_timeout");
        chk("t3_req2", reqs[2], 32'h8);
        @(negedge clk); redir_v = 1; redir_pc = 32'h100;
        @(negedge clk); redir_v = 0;
        wait_for(0, 3, "t3_deliver_timeout");
        chk("t3_dlv0", dlv[0], 32'h0);
        chk("t3_dlv1", dlv[1], 32'h4);
        chk("t3_dlv2", dlv[2], 32'h100);
        chk("t3_req3", reqs[3], 32'h100);
        chk("t3_req_count", 32'(reqs.size()), 32'd4);

        // redirect coinciding with the decode handshake
        @(negedge clk); ifr = 0; lat = 1;
        wait_for(2, 0, "t4_valid_timeout");
        chk("t4_hold_pc", ifpc, 32'h104);
        reqs.delete(); dlv.delete();
        @(negedge clk); ifr = 1; redir_v = 1; redir_pc = 32'h200;
        @(negedge clk); redir_v = 0;
        wait_for(0, 2, "t4_deliver_timeout");
        chk("t4_dlv_taken", dlv[0], 32'h104);
        chk("t4_dlv_target", dlv[1], 32'h200);
        chk("t4_req_target", reqs[0], 32'h200);

        // back-to-back redirects in S_REQ, the last one misaligned
        @(negedge clk); ready_cfg = 0;
        repeat (4) @(negedge clk);
        redir_v = 1; redir_pc = 32'h300;
        @(negedge clk); redir_pc = 32'h102; #3;
        chk("t5_mis_first", 32'(mis), 32'd0);
        chk("t5_addr_first", req_addr, 32'h300);
        @(negedge clk); redir_v = 0; #3;
        chk("t5_mis_pulse", 32'(mis), 32'd1);
        chk("t5_addr_aligned", req_addr, 32'h100);
        chk("t5_req_valid", 32'(req_v), 32'd1);
        reqs.delete(); dlv.delete();
        @(negedge clk); ready_cfg = 1; #3;
        chk("t5_mis_cleared", 32'(mis), 32'd0);
        wait_for(0, 1, "t5_deliver_timeout");
        chk("t5_req", reqs[0], 32'h100);
        chk("t5_dlv", dlv[0], 32'h100);

        // PC wrap from the top of the address space, and reset mid-wait
        @(negedge clk); rst1 = 0; reqs1.delete(); seen1 = 0;
        wait_for(3, 2, "t6_req_timeout");
        chk("t6_req0", reqs1[0], RP1);
        chk("t6_req1_wrap", reqs1[1], 32'h0);
        chk("t6_dlv_pc", pc1_s, RP1);
        chk("t6_dlv_plus4_wrap", p41_s, 32'h0);
        chk("t6_dlv_instr", ins1_s, instr_of(RP1));
        @(negedge clk); rst1 = 1;
        @(negedge clk); rst1 = 0; #3;
        chk("t6_rst_req_valid", 32'(req_v1), 32'd0);
        chk("t6_rst_req_addr", req_addr1, RP1);
        chk("t6_rst_if_valid", 32'(ifv1), 32'd0);
        chk("t6_rst_misalign", 32'(mis1), 32'd0);
        reqs1.delete(); seen1 = 0;
        wait_for(4, 0, "t6_deliver_timeout");
        chk("t6_req_after_rst", reqs1[0], RP1);
        chk("t6_dlv_after_rst", pc1_s, RP1);
        chk("t6_instr_after_rst", ins1_s, instr_of(RP1));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
